// File: rtl/zet_umi_arbiter.sv
// zet_umi_arbiter: two-master (fetch / exec) to one-slave arbiter for the Zet UMI bus.
// Exec requests win by default. A saturating starvation counter lets a waiting fetch
// win once it has lost FETCH_MAX_WAIT arbitrations in a row. A granted cycle is locked
// until the slave acks it, and the arbiter always returns to IDLE for one cycle between
// transactions.
// Optional feature: define ZET_UMI_ARB_TIMEOUT_EN to add a slave-ack timeout. On timeout
// the arbiter fakes an ack with read data 16'hffff and pulses arb_err_o.
module zet_umi_arbiter #(
  parameter int FETCH_MAX_WAIT = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] f_adr_i,
  input  logic        f_by_i,
  input  logic        f_stb_i,
  output logic [15:0] f_dat_o,
  output logic        f_ack_o,
  input  logic [19:0] e_adr_i,
  input  logic [15:0] e_dat_i,
  input  logic        e_we_i,
  input  logic        e_by_i,
  input  logic        e_tga_i,
  input  logic        e_stb_i,
  output logic [15:0] e_dat_o,
  output logic        e_ack_o,
  output logic [19:0] umi_adr_o,
  output logic [15:0] umi_dat_o,
  output logic        umi_we_o,
  output logic        umi_by_o,
  output logic        umi_tga_o,
  output logic        umi_stb_o,
  input  logic [15:0] umi_dat_i,
  input  logic        umi_ack_i,
  output logic        arb_err_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GNT_FETCH = 2'd1,
    GNT_EXEC  = 2'd2
  } state_t;

  localparam logic [3:0] MAX_WAIT   = 4'(FETCH_MAX_WAIT);
  localparam logic [3:0] STARVE_SAT = 4'hf;

  state_t     state_r;
  state_t     state_s;
  logic [3:0] starve_r;
  logic [3:0] starve_s;
  logic       tmo_s;
  logic       done_s;
  logic       in_gnt_s;

  assign in_gnt_s = (state_r != IDLE);
  // The current grant finishes this cycle, on a real slave ack or a timeout.
  assign done_s   = in_gnt_s & (umi_ack_i | tmo_s);

`ifdef ZET_UMI_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] tmo_cnt_r;

  // Count strobe cycles of the current grant; restart at every new grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_r <= 8'd0;
    end else if (!in_gnt_s || done_s) begin
      tmo_cnt_r <= 8'd0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + 8'd1;
    end
  end

  // A timeout fires on the TIMEOUT-th strobe cycle unless the slave acks in it.
  assign tmo_s     = in_gnt_s & ~umi_ack_i & (tmo_cnt_r == TMO_LAST);
  assign arb_err_o = tmo_s;
  assign f_dat_o   = tmo_s ? 16'hffff : umi_dat_i;
  assign e_dat_o   = tmo_s ? 16'hffff : umi_dat_i;
`else
  assign tmo_s     = 1'b0;
  assign arb_err_o = 1'b0;
  assign f_dat_o   = umi_dat_i;
  assign e_dat_o   = umi_dat_i;
`endif

  // Acks go only to the current owner; an ack seen while IDLE reaches nobody.
  assign f_ack_o = (state_r == GNT_FETCH) & (umi_ack_i | tmo_s);
  assign e_ack_o = (state_r == GNT_EXEC)  & (umi_ack_i | tmo_s);

  // Arbitration state and starvation counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      starve_r <= 4'd0;
    end else begin
      state_r  <= state_s;
      starve_r <= starve_s;
    end
  end

  // Next-state selection: exec priority, fetch wins once it has starved long enough.
  always_comb begin
    state_s  = state_r;
    starve_s = starve_r;
    case (state_r)
      IDLE: begin
        if (e_stb_i && f_stb_i) begin
          if (starve_r >= MAX_WAIT) begin
            state_s = GNT_FETCH;
          end else begin
            state_s = GNT_EXEC;
          end
        end else if (e_stb_i) begin
          state_s = GNT_EXEC;
        end else if (f_stb_i) begin
          state_s = GNT_FETCH;
        end else begin
          state_s = IDLE;
        end
        // Fetch lost to exec: one more lost round. Otherwise fetch is not waiting.
        if ((state_s == GNT_EXEC) && f_stb_i) begin
          if (starve_r != STARVE_SAT) begin
            starve_s = starve_r + 4'd1;
          end else begin
            starve_s = starve_r;
          end
        end else begin
          starve_s = 4'd0;
        end
      end
      GNT_FETCH, GNT_EXEC: begin
        if (done_s) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s  = IDLE;
        starve_s = 4'd0;
      end
    endcase
  end

  // Capture the winner's request into the slave port on grant; drop strobe when done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      umi_adr_o <= 20'd0;
      umi_dat_o <= 16'd0;
      umi_we_o  <= 1'b0;
      umi_by_o  <= 1'b0;
      umi_tga_o <= 1'b0;
      umi_stb_o <= 1'b0;
    end else if ((state_r == IDLE) && (state_s == GNT_EXEC)) begin
      umi_adr_o <= e_adr_i;
      umi_dat_o <= e_dat_i;
      umi_we_o  <= e_we_i;
      umi_by_o  <= e_by_i;
      umi_tga_o <= e_tga_i;
      umi_stb_o <= 1'b1;
    end else if ((state_r == IDLE) && (state_s == GNT_FETCH)) begin
      umi_adr_o <= f_adr_i;
      umi_dat_o <= 16'd0;
      umi_we_o  <= 1'b0;
      umi_by_o  <= f_by_i;
      umi_tga_o <= 1'b0;
      umi_stb_o <= 1'b1;
    end else if (done_s) begin
      umi_stb_o <= 1'b0;
    end else begin
      umi_stb_o <= umi_stb_o;
    end
  end

endmodule

// File: tb/tb_zet_umi_arbiter.sv
// Self-checking bench for zet_umi_arbiter (default build). A transaction-level model
// (current owner, captured request, count of lost fetch rounds) predicts every output
// each cycle; directed sequences add literal expectations, then random traffic runs.
module tb_zet_umi_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] f_adr_i;
  logic        f_by_i;
  logic        f_stb_i;
  logic [15:0] f_dat_o;
  logic        f_ack_o;
  logic [19:0] e_adr_i;
  logic [15:0] e_dat_i;
  logic        e_we_i;
  logic        e_by_i;
  logic        e_tga_i;
  logic        e_stb_i;
  logic [15:0] e_dat_o;
  logic        e_ack_o;
  logic [19:0] umi_adr_o;
  logic [15:0] umi_dat_o;
  logic        umi_we_o;
  logic        umi_by_o;
  logic        umi_tga_o;
  logic        umi_stb_o;
  logic [15:0] umi_dat_i;
  logic        umi_ack_i;
  logic        arb_err_o;

  zet_umi_arbiter #(.FETCH_MAX_WAIT(4), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .f_adr_i(f_adr_i), .f_by_i(f_by_i), .f_stb_i(f_stb_i), .f_dat_o(f_dat_o), .f_ack_o(f_ack_o),
    .e_adr_i(e_adr_i), .e_dat_i(e_dat_i), .e_we_i(e_we_i), .e_by_i(e_by_i), .e_tga_i(e_tga_i),
    .e_stb_i(e_stb_i), .e_dat_o(e_dat_o), .e_ack_o(e_ack_o),
    .umi_adr_o(umi_adr_o), .umi_dat_o(umi_dat_o), .umi_we_o(umi_we_o), .umi_by_o(umi_by_o),
    .umi_tga_o(umi_tga_o), .umi_stb_o(umi_stb_o), .umi_dat_i(umi_dat_i), .umi_ack_i(umi_ack_i),
    .arb_err_o(arb_err_o)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Model: owner 0 = none, 1 = fetch, 2 = exec; lost = fetch rounds lost in a row.
  int          m_owner;
  int          m_lost;
  logic [19:0] m_adr;
  logic [15:0] m_dat;
  logic        m_we;
  logic        m_by;
  logic        m_tga;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_lost  = 0;
  endtask

  // Compare every DUT output against what the model says it must be right now.
  task automatic model_check();
    chk("stb", {31'd0, umi_stb_o}, {31'd0, (m_owner != 0)});
    if (m_owner != 0) begin
      chk("adr", {12'd0, umi_adr_o}, {12'd0, m_adr});
      chk("wdat", {16'd0, umi_dat_o}, {16'd0, m_dat});
      chk("we", {31'd0, umi_we_o}, {31'd0, m_we});
      chk("by", {31'd0, umi_by_o}, {31'd0, m_by});
      chk("tga", {31'd0, umi_tga_o}, {31'd0, m_tga});
    end
    chk("f_ack", {31'd0, f_ack_o}, {31'd0, (umi_ack_i && m_owner == 1)});
    chk("e_ack", {31'd0, e_ack_o}, {31'd0, (umi_ack_i && m_owner == 2)});
    chk("f_dat", {16'd0, f_dat_o}, {16'd0, umi_dat_i});
    chk("e_dat", {16'd0, e_dat_o}, {16'd0, umi_dat_i});
    chk("err", {31'd0, arb_err_o}, 32'd0);
  endtask

  // Advance the model across the coming clock edge using the inputs now applied.
  task automatic model_step();
    int win;
    if (m_owner == 0) begin
      win = 0;
      if (e_stb_i && f_stb_i) win = (m_lost >= 4) ? 1 : 2;
      else if (e_stb_i) win = 2;
      else if (f_stb_i) win = 1;
      if (win == 2 && f_stb_i) m_lost = (m_lost < 15) ? m_lost + 1 : 15;
      else m_lost = 0;
      if (win == 2) begin
        m_adr = e_adr_i; m_dat = e_dat_i; m_we = e_we_i; m_by = e_by_i; m_tga = e_tga_i;
      end else if (win == 1) begin
        m_adr = f_adr_i; m_dat = 16'd0; m_we = 1'b0; m_by = f_by_i; m_tga = 1'b0;
      end
      m_owner = win;
    end else if (umi_ack_i) begin
      m_owner = 0;
    end
  endtask

  // One bus cycle: drive at the falling edge, check, then predict the next edge.
  task automatic cycle(input logic fs, input logic [19:0] fa, input logic es,
                       input logic [19:0] ea, input logic [15:0] ed, input logic ew,
                       input logic ack, input logic [15:0] ud,
                       input logic fb = 1'b0, input logic eb = 1'b0, input logic et = 1'b0);
    @(negedge clk);
    f_stb_i = fs; f_adr_i = fa; f_by_i = fb;
    e_stb_i = es; e_adr_i = ea; e_dat_i = ed; e_we_i = ew; e_by_i = eb; e_tga_i = et;
    umi_ack_i = ack; umi_dat_i = ud;
    #1;
    model_check();
    model_step();
  endtask

  initial begin
    logic [19:0] exp_adr;
    rst = 1'b0;
    f_stb_i = 1'b0; f_adr_i = 20'd0; f_by_i = 1'b0;
    e_stb_i = 1'b0; e_adr_i = 20'd0; e_dat_i = 16'd0; e_we_i = 1'b0; e_by_i = 1'b0; e_tga_i = 1'b0;
    umi_ack_i = 1'b0; umi_dat_i = 16'd0;
    model_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stb", {31'd0, umi_stb_o}, 32'd0);
    chk("rst_adr", {12'd0, umi_adr_o}, 32'd0);
    chk("rst_fack", {31'd0, f_ack_o}, 32'd0);
    chk("rst_eack", {31'd0, e_ack_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Fetch only, slave acks on the third strobe cycle.
    cycle(1'b1, 20'hffff0, 1'b0, 20'd0, 16'd0, 1'b0, 1'b0, 16'd0);
    cycle(1'b1, 20'hffff0, 1'b0, 20'd0, 16'd0, 1'b0, 1'b0, 16'd0);
    chk("fo_stb", {31'd0, umi_stb_o}, 32'd1);
    chk("fo_adr", {12'd0, umi_adr_o}, 32'h000ffff0);
    chk("fo_we", {31'd0, umi_we_o}, 32'd0);
    cycle(1'b1, 20'hffff0, 1'b0, 20'd0, 16'd0, 1'b0, 1'b0, 16'd0);
    cycle(1'b1, 20'hffff0, 1'b0, 20'd0, 16'd0, 1'b0, 1'b1, 16'h00ea);
    chk("fo_ack", {31'd0, f_ack_o}, 32'd1);
    chk("fo_dat", {16'd0, f_dat_o}, 32'h000000ea);
    chk("fo_eack", {31'd0, e_ack_o}, 32'd0);
    cycle(1'b0, 20'd0, 1'b0, 20'd0, 16'd0, 1'b0, 1'b0, 16'd0);
    chk("fo_low", {31'd0, umi_stb_o}, 32'd0);

    // Simultaneous requests: exec first, one strobe-low cycle, then fetch.
    cycle(1'b1, 20'h0abcd, 1'b1, 20'h00400, 16'h1234, 1'b1, 1'b0, 16'd0);
    cycle(1'b1, 20'h0abcd, 1'b1, 20'h00400, 16'h1234, 1'b1, 1'b0, 16'd0);
    chk("si_adr", {12'd0, umi_adr_o}, 32'h00000400);
    chk("si_dat", {16'd0, umi_dat_o}, 32'h00001234);
    chk("si_we", {31'd0, umi_we_o}, 32'd1);
    cycle(1'b1, 20'h0abcd, 1'b1, 20'h00400, 16'h1234, 1'b1, 1'b1, 16'h5555);
    chk("si_eack", {31'd0, e_ack_o}, 32'd1);
    cycle(1'b1, 20'h0abcd, 1'b0, 20'd0, 16'd0, 1'b0, 1'b0, 16'd0);
    chk("si_gap", {31'd0, umi_stb_o}, 32'd0);
    cycle(1'b1, 20'h0abcd, 1'b0, 20'd0, 16'd0, 1'b0, 1'b0, 16'd0);
    chk("si_fstb", {31'd0, umi_stb_o}, 32'd1);
    chk("si_fadr", {12'd0, umi_adr_o}, 32'h0000abcd);
    cycle(1'b1, 20'h0abcd, 1'b0, 20'd0, 16'd0, 1'b0, 1'b1, 16'h0001);
    chk("si_fack", {31'd0, f_ack_o}, 32'd1);
    cycle(1'b0, 20'd0, 1'b0, 20'd0, 16'd0, 1'b0, 1'b0, 16'd0);

    // Starvation: both always requesting; every fifth grant must go to fetch.
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 20'h11111, 1'b1, 20'h22222, 16'h00aa, 1'b0, 1'b0, 16'd0);
      exp_adr = ((k % 5) == 4) ? 20'h11111 : 20'h22222;
      cycle(1'b1, 20'h11111, 1'b1, 20'h22222, 16'h00aa, 1'b0, 1'b1, 16'h0f0f);
      chk("starve_adr", {12'd0, umi_adr_o}, {12'd0, exp_adr});
    end
    cycle(1'b0, 20'd0, 1'b0, 20'd0, 16'd0, 1'b0, 1'b0, 16'd0);

    // Flush: fetch drops its strobe before the ack; the cycle is still completed.
    cycle(1'b1, 20'h33333, 1'b0, 20'd0, 16'd0, 1'b0, 1'b0, 16'd0);
    cycle(1'b0, 20'd0, 1'b0, 20'd0, 16'd0, 1'b0, 1'b0, 16'd0);
    chk("fl_stb", {31'd0, umi_stb_o}, 32'd1);
    chk("fl_adr", {12'd0, umi_adr_o}, 32'h00033333);
    cycle(1'b0, 20'd0, 1'b0, 20'd0, 16'd0, 1'b0, 1'b1, 16'h7777);
    chk("fl_ack", {31'd0, f_ack_o}, 32'd1);
    cycle(1'b0, 20'd0, 1'b0, 20'd0, 16'd0, 1'b0, 1'b0, 16'd0);
    chk("fl_idle", {31'd0, umi_stb_o}, 32'd0);

    // Asynchronous reset in the middle of an exec grant.
    cycle(1'b0, 20'd0, 1'b1, 20'h44444, 16'h4444, 1'b0, 1'b0, 16'd0);
    cycle(1'b0, 20'd0, 1'b1, 20'h44444, 16'h4444, 1'b0, 1'b0, 16'd0);
    chk("ar_pre", {31'd0, umi_stb_o}, 32'd1);
    @(posedge clk);
    #2;
    umi_ack_i = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    chk("ar_stb", {31'd0, umi_stb_o}, 32'd0);
    chk("ar_eack", {31'd0, e_ack_o}, 32'd0);
    chk("ar_adr", {12'd0, umi_adr_o}, 32'd0);
    model_reset();
    @(negedge clk);
    e_stb_i = 1'b0; umi_ack_i = 1'b0;
    rst = 1'b1;
    cycle(1'b0, 20'd0, 1'b0, 20'd0, 16'd0, 1'b0, 1'b0, 16'd0);
    chk("ar_idle", {31'd0, umi_stb_o}, 32'd0);

    // Random traffic, including strobe drops, stray acks in IDLE and byte/IO flags.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom % 4) != 0, 20'($urandom), ($urandom % 2) == 0, 20'($urandom),
            16'($urandom), 1'($urandom), ($urandom % 3) == 0, 16'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/zet_umi_arbiter.md
Name: zet_umi_arbiter

Overview:
- Two-master, one-slave arbiter for the Zet UMI bus. It shares the single UMI memory port between the front-end prefetch unit (fetch master) and the execution back-end data port (exec master).
- Exec requests have priority. A starvation counter guarantees fetch forward progress.
- Each granted cycle is locked and runs until the slave acknowledges it.
- The block sits between the front-end/back-end master ports and the top-level UMI memory/IO interconnect.

Parameters:
- FETCH_MAX_WAIT, 4: number of consecutive lost arbitrations after which a pending fetch request beats a pending exec request.
- TIMEOUT, 255: slave ack timeout in cycles. Used only when the optional feature is compiled in.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- f_adr_i  input  20  fetch master address
- f_by_i  input  1  fetch byte access (1 = byte, 0 = word)
- f_stb_i  input  1  fetch request strobe
- f_dat_o  output  16  read data to fetch master
- f_ack_o  output  1  ack to fetch master
- e_adr_i  input  20  exec master address
- e_dat_i  input  16  exec write data
- e_we_i  input  1  exec write enable
- e_by_i  input  1  exec byte access
- e_tga_i  input  1  exec IO (1) / memory (0) tag
- e_stb_i  input  1  exec request strobe
- e_dat_o  output  16  read data to exec master
- e_ack_o  output  1  ack to exec master
- umi_adr_o  output  20  slave address
- umi_dat_o  output  16  slave write data
- umi_we_o  output  1  slave write enable
- umi_by_o  output  1  slave byte access
- umi_tga_o  output  1  slave IO tag
- umi_stb_o  output  1  slave strobe
- umi_dat_i  input  16  slave read data
- umi_ack_i  input  1  slave ack
- arb_err_o  output  1  timeout error pulse (optional feature only, else tied 0)

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all umi_* outputs 0; f_ack_o and e_ack_o 0; starve counter 0; arb_err_o 0.
- States: IDLE, GNT_FETCH, GNT_EXEC.
- IDLE:
  - e_stb_i only: go to GNT_EXEC.
  - f_stb_i only: go to GNT_FETCH.
  - Both: GNT_FETCH if starve_cnt >= FETCH_MAX_WAIT, else GNT_EXEC.
  - Neither: stay in IDLE.
- On entering a grant state, register the winner's adr/dat/we/by/tga into the umi_* outputs and set umi_stb_o=1.
  - Fetch grant drives umi_we_o=0, umi_tga_o=0, umi_dat_o=0.
- Latency: request seen in IDLE at cycle N → umi_stb_o high at N+1.
- Grant is locked. umi_* outputs are held stable and umi_stb_o stays high until umi_ack_i, even if the master drops its stb mid-cycle (flush).
- Ack routing:
  - f_ack_o = umi_ack_i & (state==GNT_FETCH).
  - e_ack_o = umi_ack_i & (state==GNT_EXEC).
  - Both are combinational, same cycle as umi_ack_i.
- f_dat_o and e_dat_o are driven combinationally from umi_dat_i.
- Ack cycle: the next state is IDLE and umi_stb_o goes 0 at the following edge. There is always at least one stb-low cycle between transactions.
- Starve counter (3+ bits, saturating):
  - Increments when IDLE grants exec while f_stb_i=1.
  - Clears when fetch is granted or f_stb_i=0 in IDLE.
- Simultaneous ack and new requests: the requests are ignored until IDLE. The ack applies only to the current owner.
- Any umi_ack_i while in IDLE is ignored; no master ack is generated.
- Reset asserted mid-cycle: outputs clear immediately and the cycle is abandoned. Masters must restart.

Optional Feature:
- Macro: ZET_UMI_ARB_TIMEOUT_EN.
- Defined:
  - An 8+ bit cycle counter runs during GNT_* states.
  - If no umi_ack_i arrives after TIMEOUT cycles, the arbiter:
    - asserts the owner's ack for one cycle with read data forced to 16'hffff;
    - pulses arb_err_o for one cycle;
    - drops umi_stb_o and returns to IDLE.
  - A late slave ack arriving in IDLE is discarded.
- Undefined: no counter, arb_err_o tied 0, and the grant is held indefinitely until ack.

Test Plan:
- Fetch only:
  - Stimulus: f_stb_i=1, f_adr_i=20'hffff0; slave acks 2 cycles after stb with umi_dat_i=16'h00ea.
  - Response: umi_stb_o rises 1 cycle after the request; umi_we_o=0; f_ack_o pulses with f_dat_o=16'h00ea; e_ack_o stays 0.
- Simultaneous requests:
  - Stimulus: f_stb_i and e_stb_i both high in IDLE; e_we_i=1, e_adr_i=20'h00400, e_dat_i=16'h1234.
  - Response: exec granted first, with umi_adr_o=20'h00400, umi_dat_o=16'h1234, umi_we_o=1; after its ack, one stb-low cycle, then fetch is granted.
- Starvation:
  - Stimulus: f_stb_i held high; exec re-requests continuously.
  - Response: after 4 exec grants, the 5th arbitration grants fetch; starve_cnt then returns to 0.
- Flush mid-cycle:
  - Stimulus: fetch granted; f_stb_i drops before ack.
  - Response: umi_stb_o and umi_adr_o are held until umi_ack_i; f_ack_o still pulses; then IDLE.
- Async reset:
  - Stimulus: rst driven low during GNT_EXEC, between clock edges.
  - Response: umi_stb_o=0 and e_ack_o=0 immediately, without waiting for a clock edge; after reset release, state is IDLE.
- Timeout (ZET_UMI_ARB_TIMEOUT_EN, TIMEOUT=8):
  - Stimulus: exec read, slave never acks.
  - Response: e_ack_o pulses after 8 stb cycles with e_dat_o=16'hffff; arb_err_o pulses once; umi_stb_o goes 0.
